// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit RISC CPU.
// Opcodes, sequencer states and opcode class helpers.
package cpu_pkg;

   localparam logic [2:0] HLT = 3'b000;
   localparam logic [2:0] SKZ = 3'b001;
   localparam logic [2:0] ADD = 3'b010;
   localparam logic [2:0] AND = 3'b011;
   localparam logic [2:0] XOR = 3'b100;
   localparam logic [2:0] LDA = 3'b101;
   localparam logic [2:0] STO = 3'b110;
   localparam logic [2:0] JMP = 3'b111;

   typedef enum logic [3:0] {
      S_PAUSE,
      S_P0,
      S_P1,
      S_P2,
      S_P3,
      S_P4,
      S_P5,
      S_P6,
      S_P7,
      S_HALTED
   } state_t;

   function automatic logic is_aluop(input logic [2:0] op);
      return (op == ADD) || (op == AND) ||
             (op == XOR) || (op == LDA);
   endfunction

endpackage

// File: rtl/cpu_phase_controller.sv
// 8-phase instruction sequencer with run/pause, single-step and halt.
// Drives memory, IR, accumulator strobes and the PC retire enable.
module cpu_phase_controller
   import cpu_pkg::*;
#(
   parameter int OPCODE_W = 3,
   parameter int ICNT_W   = 16
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                run,
   input  logic                step,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                acc_zero,
   output logic                sel,
   output logic                rd,
   output logic                ld_ir,
   output logic                ld_ac,
   output logic                data_e,
   output logic                wr,
   output logic                pc_en,
   output logic                skz_cmp,
   output logic                halted,
   output logic                paused,
   output logic [2:0]          phase,
   output logic [ICNT_W-1:0]   instr_count
);

   state_t              state;
   state_t              state_nx;
   logic [OPCODE_W-1:0] op_q;
   logic                alu;
   logic                sto;

   assign alu = is_aluop(op_q[2:0]);
   assign sto = (op_q[2:0] == STO);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= S_PAUSE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_PAUSE:  if (run || step) state_nx = S_P0;
         S_P0:     state_nx = S_P1;
         S_P1:     state_nx = S_P2;
         S_P2:     state_nx = S_P3;
         S_P3:     state_nx = S_P4;
         S_P4:     state_nx = (op_q[2:0] == HLT) ? S_HALTED : S_P5;
         S_P5:     state_nx = S_P6;
         S_P6:     state_nx = S_P7;
         S_P7:     state_nx = run ? S_P0 : S_PAUSE;
         S_HALTED: state_nx = S_HALTED;
         default:  state_nx = S_PAUSE;
      endcase
   end

   always_comb begin
      sel    = 1'b0;
      rd     = 1'b0;
      ld_ir  = 1'b0;
      ld_ac  = 1'b0;
      data_e = 1'b0;
      wr     = 1'b0;
      pc_en  = 1'b0;
      halted = 1'b0;
      paused = 1'b0;
      phase  = 3'd0;
      unique case (state)
         S_PAUSE:  paused = 1'b1;
         S_P0: begin
            phase = 3'd0;
            sel   = 1'b1;
         end
         S_P1: begin
            phase = 3'd1;
            sel   = 1'b1;
            rd    = 1'b1;
         end
         S_P2, S_P3: begin
            phase = (state == S_P2) ? 3'd2 : 3'd3;
            sel   = 1'b1;
            rd    = 1'b1;
            ld_ir = 1'b1;
         end
         S_P4:     phase = 3'd4;
         S_P5: begin
            phase = 3'd5;
            rd    = alu;
         end
         S_P6: begin
            phase  = 3'd6;
            rd     = alu;
            data_e = sto;
         end
         S_P7: begin
            phase  = 3'd7;
            rd     = alu;
            ld_ac  = alu;
            data_e = sto;
            wr     = sto;
            pc_en  = 1'b1;
         end
         S_HALTED: halted = 1'b1;
         default:  paused = 1'b0;
      endcase
   end

   // op_q is captured once per instruction; skz_cmp holds until next P6
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         op_q        <= '0;
         skz_cmp     <= 1'b0;
         instr_count <= '0;
      end else begin
         if (state == S_P3) op_q <= opcode;
         if (state == S_P6) skz_cmp <= acc_zero && (op_q[2:0] == SKZ);
         if (state == S_P7) instr_count <= instr_count + 1'b1;
      end
   end

endmodule

// File: doc/cpu_phase_controller.md
Name: cpu_phase_controller

Overview:
- 8-phase instruction sequencer for the 8-bit RISC CPU.
- Steps every instruction through fetch, decode, operand and execute phases, and drives the memory, IR, accumulator and ALU strobes.
- Issues the one-cycle PC enable (En_cpu_in of the program counter) that retires each instruction.
- Adds run/pause, single-step and a terminal halt, and sits between the instruction register and the datapath.

Parameters:
- OPCODE_W, 3, opcode width taken from IR[7:5].
- ICNT_W, 16, width of the retired-instruction counter.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- run  in  1  level; 1 = free-run, 0 = pause at the next instruction boundary.
- step  in  1  one-cycle pulse; executes exactly one instruction while paused.
- opcode  in  OPCODE_W  IR opcode; sampled in phase 3 only.
- acc_zero  in  1  accumulator == 0 flag from the ALU.
- sel  out  1  address mux select: 1 = PC, 0 = IR operand address.
- rd  out  1  memory read strobe.
- ld_ir  out  1  instruction register load.
- ld_ac  out  1  accumulator load.
- data_e  out  1  accumulator drives the data bus.
- wr  out  1  memory write strobe.
- pc_en  out  1  one-cycle program counter update enable.
- skz_cmp  out  1  registered (acc_zero at phase 6) AND opcode==SKZ, stable through phase 7.
- halted  out  1  in HALTED state.
- paused  out  1  in PAUSE state.
- phase  out  3  current phase 0..7; 0 while in PAUSE or HALTED.
- instr_count  out  ICNT_W  retired-instruction count; wraps modulo 2^ICNT_W.

Behaviour:
- States: PAUSE, P0 INST_ADDR, P1 INST_FETCH, P2 INST_LOAD, P3 IDLE, P4 OP_ADDR, P5 OP_FETCH, P6 ALU_OP, P7 STORE, HALTED. One state per clock.
- Reset (reset=0): state=PAUSE; op_q=0; skz_cmp=0; instr_count=0. Every other output is 0 except paused=1.
- PAUSE: run=1 or step=1 -> P0, else stay. Step pulses outside PAUSE are ignored, not queued.
- P0->P1->P2->P3->P4 unconditionally.
- Opcode is latched into op_q at P3 and used for all decoding from P4 onward.
- P4: op_q==HLT(000) -> HALTED. Otherwise -> P5.
- P5->P6->P7.
- P7 -> P0 if run=1, else PAUSE. A step-initiated instruction therefore ends in PAUSE.
- HALTED is terminal and is left only by reset. In HALTED all strobes are 0, pc_en is never issued and halted=1.
- Strobes are a Moore decode of state and op_q. ALUOP = ADD(010), AND(011), XOR(100), LDA(101). STO = 110.
  - P0: sel.
  - P1: sel, rd.
  - P2: sel, rd, ld_ir.
  - P3: sel, rd, ld_ir.
  - P4: none.
  - P5: rd if ALUOP.
  - P6: rd if ALUOP; data_e if STO.
  - P7: rd and ld_ac if ALUOP; data_e and wr if STO; pc_en always.
- SKZ(001) and JMP(111) assert no memory strobes in P5–P7. The PC resolves them from opcode and skz_cmp when pc_en is high.
- instr_count increments by 1 on each P7 cycle. HLT never retires and never counts.
- Latency: 8 cycles per instruction in free-run. Back-to-back instructions have no idle cycle.
- run falling mid-instruction completes the instruction and then pauses.
- Reset asserted mid-instruction aborts immediately to PAUSE; no partial wr or pc_en after reset release.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants HLT, SKZ, ADD, AND, XOR, LDA, STO, JMP;
  - the state enum;
  - the ALUOP membership function.
- No sub-module; the FSM and the strobe decode stay in one module. The package is reused by the ALU and the program counter.

Test Plan:
- Reset with run=0 -> paused=1, all strobes 0, phase=0; remains so for 20 cycles.
- run=1, opcode=LDA(101) -> P0..P7 in 8 cycles; rd in P5–P7; ld_ac and pc_en only in P7; instr_count=1.
- opcode=STO(110) -> data_e in P6–P7, wr only in P7, rd=0 in P5–P7; pc_en one pulse.
- opcode=SKZ, acc_zero=1 at P6 -> skz_cmp=1 in P7 with pc_en=1. Repeat with acc_zero=0 -> skz_cmp=0.
- run=0, single step pulse while paused -> exactly one 8-phase instruction, back to PAUSE, instr_count+1. A step pulse during P3 has no effect.
- opcode=HLT -> HALTED after P4, pc_en never asserted, instr_count unchanged, run/step ignored. reset=0 for 1 cycle -> PAUSE, count=0.
